hazard_controller: RTL and testbench

- Sequences the decode stage of the 5-stage ARM pipeline.
- Keeps an internal scoreboard of in-flight register writes in the EXE, MEM and WB slots.
- From that scoreboard it generates the decode-stage `hazard` stall, the front-end freeze, the branch flush and the whole-pipe freeze that the memory controller requests.
- It sits beside the ID stage, takes the ID-stage decode fields as inputs, and drives the pipeline-register enable/flush controls.

---
 rtl/arm_pipe_pkg.sv | 22 ++
 rtl/hazard_controller_if.sv | 38 +++
 rtl/hazard_controller_sb_match.sv | 14 +
 rtl/hazard_controller.sv | 130 +++++++++++++
 tb/tb_hazard_controller.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared decode-stage types for the 5-stage ARM pipeline: register specifier
// width, the in-flight write scoreboard entry and the per-cycle advance action.
package arm_pipe_pkg;

  localparam int REG_W = 4;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dest;
    logic             wb;
    logic             ld;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{v: 1'b0, dest: {REG_W{1'b0}}, wb: 1'b0, ld: 1'b0};

  typedef enum logic [1:0] {
    ACT_ISSUE  = 2'b00,
    ACT_BUBBLE = 2'b01,
    ACT_HOLD   = 2'b10
  } sb_action_t;

endpackage

// File: rtl/hazard_controller_if.sv
// ID-stage decode fields in, pipeline-register controls out; sb_view exposes
// the scoreboard contents (EXE at index 0, WB at index 2) for observation.
interface hazard_controller_if #(
  parameter int STALL_CNT_W = 16
);
  import arm_pipe_pkg::*;

  logic                   fwd_en;
  logic                   id_valid;
  logic [REG_W-1:0]       src1;
  logic                   src1_used;
  logic [REG_W-1:0]       src2;
  logic                   two_src;
  logic                   id_wb_en;
  logic                   id_mem_r_en;
  logic [REG_W-1:0]       id_dest;
  logic                   branch_taken;
  logic                   mem_busy;
  logic                   hazard;
  logic                   freeze_front;
  logic                   freeze_pipe;
  logic                   flush;
  logic [STALL_CNT_W-1:0] stall_cnt;
  sb_entry_t [2:0]        sb_view;

  modport master (
    output fwd_en, id_valid, src1, src1_used, src2, two_src,
           id_wb_en, id_mem_r_en, id_dest, branch_taken, mem_busy,
    input  hazard, freeze_front, freeze_pipe, flush, stall_cnt, sb_view
  );

  modport slave (
    input  fwd_en, id_valid, src1, src1_used, src2, two_src,
           id_wb_en, id_mem_r_en, id_dest, branch_taken, mem_busy,
    output hazard, freeze_front, freeze_pipe, flush, stall_cnt, sb_view
  );

endinterface

// File: rtl/hazard_controller_sb_match.sv
// One source operand against one scoreboard slot: hit only for a live,
// register-writing entry whose destination equals the operand.
module sb_match
  import arm_pipe_pkg::*;
(
  input  sb_entry_t        i_entry,
  input  logic [REG_W-1:0] i_reg,
  input  logic             i_used,
  output logic             o_match
);

  assign o_match = i_used & i_entry.v & i_entry.wb & (i_entry.dest == i_reg);

endmodule

// File: rtl/hazard_controller.sv
// Decode-stage hazard controller: tracks in-flight writes in EXE/MEM/WB and
// drives bubble, flush and freeze controls with zero-cycle latency to ID.
module hazard_controller
  import arm_pipe_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  hazard_controller_if.slave bus
);

  sb_entry_t              r_exe;
  sb_entry_t              r_mem;
  sb_entry_t              r_wb;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  sb_entry_t              w_id_entry;
  sb_action_t             w_action;
  logic                   w_use1;
  logic                   w_use2;
  logic                   w_s1_exe;
  logic                   w_s2_exe;
  logic                   w_s1_mem;
  logic                   w_s2_mem;
  logic                   w_raw;
  logic                   w_hazard;
  logic                   w_flush;
  logic                   w_freeze_front;
  logic                   w_freeze_pipe;

  assign w_use1 = bus.id_valid & bus.src1_used;
  assign w_use2 = bus.id_valid & bus.two_src;

  assign w_id_entry = '{v:    bus.id_valid,
                        dest: bus.id_dest,
                        wb:   bus.id_wb_en & bus.id_valid,
                        ld:   bus.id_mem_r_en & bus.id_valid};

  sb_match u_s1_exe (.i_entry(r_exe), .i_reg(bus.src1), .i_used(w_use1), .o_match(w_s1_exe));
  sb_match u_s2_exe (.i_entry(r_exe), .i_reg(bus.src2), .i_used(w_use2), .o_match(w_s2_exe));
  sb_match u_s1_mem (.i_entry(r_mem), .i_reg(bus.src1), .i_used(w_use1), .o_match(w_s1_mem));
  sb_match u_s2_mem (.i_entry(r_mem), .i_reg(bus.src2), .i_used(w_use2), .o_match(w_s2_mem));

  // WB is never consulted: the register file writes on the opposite edge.
  always_comb begin
    w_raw = 1'b0;
    if (bus.fwd_en) begin
      w_raw = (w_s1_exe | w_s2_exe) & r_exe.ld;
    end else begin
      w_raw = w_s1_exe | w_s2_exe | w_s1_mem | w_s2_mem;
    end
  end

  // Controls are forced low while reset is held, even if busy/branch are asserted.
  always_comb begin
    w_action       = ACT_ISSUE;
    w_hazard       = 1'b0;
    w_flush        = 1'b0;
    w_freeze_front = 1'b0;
    w_freeze_pipe  = 1'b0;
    if (!rst) begin
      w_action = ACT_HOLD;
    end else if (bus.mem_busy) begin
      w_action       = ACT_HOLD;
      w_freeze_front = 1'b1;
      w_freeze_pipe  = 1'b1;
    end else if (bus.branch_taken) begin
      w_action = ACT_BUBBLE;
      w_flush  = 1'b1;
    end else if (w_raw) begin
      w_action       = ACT_BUBBLE;
      w_hazard       = 1'b1;
      w_freeze_front = 1'b1;
    end else begin
      w_action = ACT_ISSUE;
    end
  end

  // Scoreboard advance: issue the ID instruction, insert a bubble, or freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exe <= SB_EMPTY;
      r_mem <= SB_EMPTY;
      r_wb  <= SB_EMPTY;
    end else begin
      case (w_action)
        ACT_ISSUE: begin
          r_exe <= w_id_entry;
          r_mem <= r_exe;
          r_wb  <= r_mem;
        end
        ACT_BUBBLE: begin
          r_exe <= SB_EMPTY;
          r_mem <= r_exe;
          r_wb  <= r_mem;
        end
        ACT_HOLD: begin
          r_exe <= r_exe;
          r_mem <= r_mem;
          r_wb  <= r_wb;
        end
        default: begin
          r_exe <= SB_EMPTY;
          r_mem <= SB_EMPTY;
          r_wb  <= SB_EMPTY;
        end
      endcase
    end
  end

  // Saturating count of bubble-inserting hazard cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= {STALL_CNT_W{1'b0}};
    end else if (w_hazard && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign bus.hazard       = w_hazard;
  assign bus.flush        = w_flush;
  assign bus.freeze_front = w_freeze_front;
  assign bus.freeze_pipe  = w_freeze_pipe;
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.sb_view      = {r_wb, r_mem, r_exe};

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller: the driver queues hand-computed
// expectations per cycle, a monitor pops and compares them mid-cycle.
module tb_hazard_controller;
  import arm_pipe_pkg::*;

  typedef struct {
    int          id;
    logic [3:0]  o;      // {hazard, freeze_front, freeze_pipe, flush}
    int          cnt;
    bit          chk;
    logic [20:0] view;   // {WB, MEM, EXE} entries, each {v, dest, wb, ld}
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  int   n_vec;
  int   n_bad;
  int   idx;

  hazard_controller_if #(.STALL_CNT_W(16)) bus ();

  hazard_controller #(.STALL_CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  function automatic logic [6:0] ent(input int v, input int d, input int wb, input int ld);
    logic [6:0] e;
    e = {v[0], d[3:0], wb[0], ld[0]};
    return e;
  endfunction

  task automatic step(input int rv, input int fwd, input int v, input int d, input int wb,
                      input int ld, input int s1, input int u1, input int s2, input int u2,
                      input int br, input int busy, input int eo, input int cnt,
                      input int chk, input logic [20:0] view);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = rv[0];
    bus.fwd_en       = fwd[0];
    bus.id_valid     = v[0];
    bus.id_dest      = d[3:0];
    bus.id_wb_en     = wb[0];
    bus.id_mem_r_en  = ld[0];
    bus.src1         = s1[3:0];
    bus.src1_used    = u1[0];
    bus.src2         = s2[3:0];
    bus.two_src      = u2[0];
    bus.branch_taken = br[0];
    bus.mem_busy     = busy[0];
    e.id   = idx;
    e.o    = eo[3:0];
    e.cnt  = cnt;
    e.chk  = (chk != 0);
    e.view = view;
    q.push_back(e);
    idx++;
  endtask

  // Monitor: one comparison per queued vector, sampled on the falling edge.
  initial begin
    exp_t        e;
    logic [3:0]  got_o;
    logic [20:0] got_v;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e     = q.pop_front();
        got_o = {bus.hazard, bus.freeze_front, bus.freeze_pipe, bus.flush};
        got_v = bus.sb_view;
        n_vec++;
        if (got_o !== e.o || bus.stall_cnt !== e.cnt[15:0] || (e.chk && got_v !== e.view)) begin
          n_bad++;
          $display("FAIL vec%0d: haz/ff/fp/fl=%b cnt=%0d sb=%h, expected %b cnt=%0d sb=%h%s",
                   e.id, got_o, bus.stall_cnt, got_v, e.o, e.cnt, e.view, e.chk ? "" : " (sb unchecked)");
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d vectors pending", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    logic [20:0] ldr3;
    logic [20:0] ldr4;
    ldr3 = {14'd0, ent(1, 3, 1, 1)};
    ldr4 = {14'd0, ent(1, 4, 1, 1)};
    n_vec = 0; n_bad = 0; idx = 0;
    rst = 1'b0;
    bus.fwd_en = 1'b0; bus.id_valid = 1'b0; bus.id_dest = 4'd0; bus.id_wb_en = 1'b0;
    bus.id_mem_r_en = 1'b0; bus.src1 = 4'd0; bus.src1_used = 1'b0; bus.src2 = 4'd0;
    bus.two_src = 1'b0; bus.branch_taken = 1'b0; bus.mem_busy = 1'b0;

    // rv fwd v  d wb ld s1 u1 s2 u2 br bz  out     cnt chk view
    // reset: controls low even with busy/branch/operands asserted
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'b0000, 0, 1, 21'd0);
    step(0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 'b0000, 0, 1, 21'd0);
    // no-forward RAW: ADD R1 then SUB reading R1 stalls 2 cycles
    step(1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0, 21'd0);
    step(1, 0, 1, 3, 1, 0, 1, 1, 0, 0, 0, 0, 'b1100, 0, 0, 21'd0);
    step(1, 0, 1, 3, 1, 0, 1, 1, 0, 0, 0, 0, 'b1100, 1, 0, 21'd0);
    step(1, 0, 1, 3, 1, 0, 1, 1, 0, 0, 0, 0, 'b0000, 2, 0, 21'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 2, 0, 21'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 2, 0, 21'd0);
    // forwarded ALU results never stall (EXE and MEM consumers)
    step(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 'b0000, 2, 0, 21'd0);
    step(1, 1, 1, 4, 1, 0, 1, 1, 0, 0, 0, 0, 'b0000, 2, 0, 21'd0);
    step(1, 1, 1, 5, 1, 0, 0, 0, 1, 1, 0, 0, 'b0000, 2, 0, 21'd0);
    // fwd off: WB hit on R1 ignored; stale dest of a non-writing entry ignored
    step(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 'b0000, 2, 0, 21'd0);
    step(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'b0000, 2, 0, 21'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 2, 0, 21'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 2, 0, 21'd0);
    // load-use: LDR R2 then ADD using src2=R2 stalls exactly 1 cycle
    step(1, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 'b0000, 2, 0, 21'd0);
    step(1, 1, 1, 6, 1, 0, 0, 0, 2, 1, 0, 0, 'b1100, 2, 0, 21'd0);
    step(1, 1, 1, 6, 1, 0, 0, 0, 2, 1, 0, 0, 'b0000, 3, 0, 21'd0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 3, 0, 21'd0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 3, 0, 21'd0);
    // source gating: two_src=0, id_valid=0, and a store's stale dest
    step(1, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 'b0000, 3, 0, 21'd0);
    step(1, 1, 1, 8, 0, 0, 7, 1, 2, 0, 0, 0, 'b0000, 3, 0, 21'd0);
    step(1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 'b0000, 3, 0, 21'd0);
    step(1, 0, 1, 9, 0, 0, 8, 1, 0, 0, 0, 0, 'b0000, 3, 0, 21'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 3, 0, 21'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 3, 0, 21'd0);
    // branch beats load-use stall; killed instruction (dest R10) must not enter EXE
    step(1, 1, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 'b0000, 3, 0, 21'd0);
    step(1, 1, 1, 10, 1, 1, 3, 1, 0, 0, 1, 0, 'b0001, 3, 1, ldr3);
    step(1, 1, 1, 0, 0, 0, 10, 1, 0, 0, 0, 0, 'b0000, 3, 1, ldr3 << 7);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 3, 0, 21'd0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 3, 0, 21'd0);
    // mem_busy for 3 cycles over a pending load-use, stall follows
    step(1, 1, 1, 4, 1, 1, 0, 0, 0, 0, 0, 0, 'b0000, 3, 0, 21'd0);
    step(1, 1, 1, 11, 1, 0, 4, 1, 0, 0, 0, 1, 'b0110, 3, 1, ldr4);
    step(1, 1, 1, 11, 1, 0, 4, 1, 0, 0, 0, 1, 'b0110, 3, 1, ldr4);
    step(1, 1, 1, 11, 1, 0, 4, 1, 0, 0, 0, 1, 'b0110, 3, 1, ldr4);
    step(1, 1, 1, 11, 1, 0, 4, 1, 0, 0, 0, 0, 'b1100, 3, 1, ldr4);
    step(1, 1, 1, 5, 1, 1, 4, 1, 0, 0, 0, 0, 'b0000, 4, 1, ldr4 << 7);
    // reset pulsed in the middle of a 2-cycle no-forward stall
    step(1, 0, 1, 12, 1, 0, 5, 1, 0, 0, 0, 0, 'b1100, 4, 0, 21'd0);
    step(0, 0, 1, 12, 1, 0, 5, 1, 0, 0, 0, 0, 'b0000, 0, 1, 21'd0);
    step(1, 0, 1, 12, 1, 0, 5, 1, 0, 0, 0, 0, 'b0000, 0, 1, 21'd0);
    // branch held through mem_busy acts on the first non-busy cycle
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'b0110, 0, 0, 21'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'b0001, 0, 0, 21'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0, 21'd0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors never compared, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
